// File: rtl/umac_pkg.sv
// Shared types and helpers for the uMac response collector: FSM states,
// default MISR constants, the MISR step and the two-word response fold.
package umac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_e;

  localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;

  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] d,
                                            input logic [31:0] poly = DEF_POLY);
    return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ d;
  endfunction

  // Half-word swap of out2 keeps the two uMac outputs from cancelling each other.
  function automatic logic [31:0] fold(input logic [31:0] out1,
                                       input logic [31:0] out2);
    return out1 ^ {out2[15:0], out2[31:16]};
  endfunction

endpackage

// File: rtl/umac_misr32.sv
// 32-bit registered MISR with synchronous seed load (priority) and absorb enable.
module umac_misr32
  import umac_pkg::*;
#(
  parameter logic [31:0] SEED = DEF_SEED,
  parameter logic [31:0] POLY = DEF_POLY
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [31:0] i_d,
  output logic [31:0] o_sig,
  output logic [31:0] o_sig_next
);

  assign o_sig_next = misr_step(o_sig, i_d, POLY);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_sig <= SEED;
    else if (i_load) o_sig <= SEED;
    else if (i_en)   o_sig <= o_sig_next;
  end

endmodule

// File: rtl/umac_resp_collector.sv
// Compacts the uMac o_out1/o_out2 stream into one MISR signature per
// {mode, task} segment and banks them for readback.
// Optional: define UMAC_COLL_GAP_CNT_EN to add the o_gap_cnt idle-cycle counter.
module umac_resp_collector
  import umac_pkg::*;
#(
  parameter int          SEG_LEN = 65536,
  parameter int          NUM_SEG = 8,
  parameter logic [31:0] SEED    = DEF_SEED,
  parameter logic [31:0] POLY    = DEF_POLY
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [1:0]  i_task,
  input  logic        i_mode,
  input  logic [31:0] i_out1,
  input  logic [31:0] i_out2,
  input  logic [2:0]  i_rd_idx,
  output logic [31:0] o_rd_sig,
  output logic        o_busy,
  output logic        o_seg_done,
  output logic        o_done,
  output logic        o_seq_err,
  output logic [16:0] o_cnt
`ifdef UMAC_COLL_GAP_CNT_EN
  ,
  output logic [31:0] o_gap_cnt
`endif
);

  localparam int          IDX_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [16:0] LAST_CNT = 17'(SEG_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_SEG - 1);

  state_e           state_q, state_d;
  logic             enter, take, close;
  logic [IDX_W-1:0] seg_idx_q;
  logic [2:0]       seg_key_q, key_in, key_eff;
  logic [31:0]      sig, sig_next;
  logic [31:0]      bank [NUM_SEG];

  assign key_in  = {i_mode, i_task};
  // On a segment's first sample the key register is not loaded yet.
  assign key_eff = (o_cnt == 17'd0) ? key_in : seg_key_q;
  assign o_busy  = (state_q == ST_COLLECT);
  assign o_done  = (state_q == ST_DONE);

  umac_misr32 #(.SEED(SEED), .POLY(POLY)) u_misr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (enter | close),
    .i_en       (take),
    .i_d        (fold(i_out1, i_out2)),
    .o_sig      (sig),
    .o_sig_next (sig_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    take    = 1'b0;
    close   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          enter   = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (i_start) begin
          enter = 1'b1;
        end else if (i_valid) begin
          take = 1'b1;
          if (o_cnt == LAST_CNT) begin
            close = 1'b1;
            if (seg_idx_q == LAST_SEG) state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt      <= 17'd0;
      seg_idx_q  <= '0;
      seg_key_q  <= 3'd0;
      o_seq_err  <= 1'b0;
      o_seg_done <= 1'b0;
    end else begin
      o_seg_done <= close;
      if (enter) begin
        o_cnt     <= 17'd0;
        seg_idx_q <= '0;
        o_seq_err <= 1'b0;
      end else if (take) begin
        if (o_cnt == 17'd0)       seg_key_q <= key_in;
        else if (key_in != seg_key_q) o_seq_err <= 1'b1;
        if (close) begin
          o_cnt     <= 17'd0;
          seg_idx_q <= (seg_idx_q == LAST_SEG) ? '0 : seg_idx_q + IDX_W'(1);
        end else begin
          o_cnt <= o_cnt + 17'd1;
        end
      end
    end
  end

  // NOTE: the bank is only eight words and must read back as zero after
  // reset, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_SEG; i++) bank[i] <= 32'h0;
      o_rd_sig <= 32'h0;
    end else begin
      if (close) bank[key_eff] <= sig_next;
      o_rd_sig <= bank[i_rd_idx];
    end
  end

`ifdef UMAC_COLL_GAP_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_gap_cnt <= 32'h0;
    else if (enter)
      o_gap_cnt <= 32'h0;
    else if (o_busy && !i_valid && (o_gap_cnt != 32'hFFFF_FFFF))
      o_gap_cnt <= o_gap_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/umac_resp_collector.md
Name: umac_resp_collector

Overview:
- Response-side companion to the uMac stimulus sweep. The sweep drives operands, task and mode into uMac; this block consumes uMac's o_out1/o_out2 stream.
- Compacts the stream into one 32-bit MISR signature per {mode, task} segment and stores each signature in a bank for readback.
- Synthesizable, so a uMac sweep can be self-checked on silicon/FPGA, not only in simulation.

Parameters:
- SEG_LEN, 65536: valid samples per segment (256x256 operand sweep).
- NUM_SEG, 8: segments per run (4 tasks x 2 modes); bank depth.
- SEED, 32'hFFFF_FFFF: MISR value at every segment start.
- POLY, 32'h04C1_1DB7: MISR feedback polynomial.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begin or restart a run.
- i_valid  in  1  sample qualifier for i_out1/i_out2.
- i_task  in  2  task applied to uMac for this sample.
- i_mode  in  1  mode applied to uMac for this sample.
- i_out1  in  32  uMac o_out1.
- i_out2  in  32  uMac o_out2.
- i_rd_idx  in  3  bank readback index.
- o_rd_sig  out  32  bank[i_rd_idx], registered.
- o_busy  out  1  high in COLLECT.
- o_seg_done  out  1  one-cycle pulse when a segment's signature is stored.
- o_done  out  1  high in DONE.
- o_seq_err  out  1  sticky: {mode, task} changed inside a segment.
- o_cnt  out  17  samples taken in the current segment.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE.
  - sig=SEED; o_cnt=0; seg_idx=0.
  - All bank entries=0; o_rd_sig=0.
  - o_busy, o_seg_done, o_done and o_seq_err are 0.
  - Release takes effect on the next i_clk edge.
- IDLE: i_start -> COLLECT. On entry: sig=SEED, o_cnt=0, seg_idx=0, o_seq_err=0. Samples are ignored.
- COLLECT, each cycle with i_valid=1:
  - d = i_out1 ^ {i_out2[15:0], i_out2[31:16]}.
  - sig_next = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 0) ^ d.
  - o_cnt increments by 1.
  - The first sample of a segment latches seg_key={i_mode, i_task}. Any later sample in the segment with a different {i_mode, i_task} sets o_seq_err. The sample is still absorbed and seg_key is unchanged.
- Segment close: happens on the valid sample that makes o_cnt reach SEG_LEN. On the next edge:
  - bank[seg_key] is written with sig_next.
  - o_seg_done pulses for 1 cycle.
  - sig=SEED; o_cnt=0; seg_idx increments.
  - If the closed segment was number NUM_SEG (seg_idx wraps from NUM_SEG-1), go to DONE.
- i_valid=0 in COLLECT: sig and o_cnt hold.
- DONE: o_done=1. Samples are ignored. i_start -> COLLECT (new run); the bank is kept until overwritten.
- i_start in COLLECT: abort and restart as on entry. The partial segment is discarded and the bank is unchanged. i_start has priority over a simultaneous valid sample.
- Readback: o_rd_sig = bank[i_rd_idx] one cycle after i_rd_idx. It is legal in every state. A same-cycle bank write is seen on the following read cycle.
- Total latency from the last sample to o_done: 1 cycle.
- o_cnt never wraps; it always closes at SEG_LEN.

Optional Feature:
- Macro UMAC_COLL_GAP_CNT_EN.
- Defined: adds output o_gap_cnt (32 bits). It counts COLLECT cycles with i_valid=0, saturates at 32'hFFFF_FFFF, clears on reset and on COLLECT entry, and holds in DONE.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package umac_pkg:
  - FSM state enum (IDLE, COLLECT, DONE).
  - Default SEED and POLY constants.
  - Function misr_step(sig, d).
  - Function fold(out1, out2) computing d.
- Sub-module umac_misr32: registered MISR with seed-load and enable; the top holds the FSM, counters and bank.

Test Plan:
- Reset mid-COLLECT (SEG_LEN=1) -> all outputs return to their reset values asynchronously; after release, IDLE ignores i_valid.
- SEG_LEN=1; i_start, then one valid sample with i_out1=0, i_out2=0, task 0, mode 0 -> o_seg_done pulses and bank[0]=32'hFB3E_E249.
- SEG_LEN=1, NUM_SEG=8; 8 samples sweeping {mode, task} 0..7 -> 8 o_seg_done pulses, then o_done=1; reading idx 0..7 matches the reference misr_step values.
- SEG_LEN=4; task changes from 1 to 2 on the 3rd sample -> o_seq_err=1, and the signature is stored in bank[1].
- SEG_LEN=4; i_start after 2 samples -> o_cnt=0, the bank is unchanged, and the next 4 samples give the same signature as a clean run.
- Define UMAC_COLL_GAP_CNT_EN; insert 5 idle cycles during COLLECT -> o_gap_cnt=5, and it holds in DONE.
